// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
// Write-domain pointer and status controller for an asynchronous FIFO.
// It keeps the binary write pointer and its Gray-coded copy for the
// read-side synchronizer, and drives the RAM write enable and address.
// The read pointer comes in Gray code, already synchronized to wclk,
// and is used to derive full, almost-full, fill level and a sticky
// overflow flag. All status is conservative: the synchronized read
// pointer lags the reader, so the level can only be overestimated.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic                  wovf_clr,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    // Threshold resized to the pointer width; 2^ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] LP_AFULL_THRESH = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    // Binary to Gray: neighbouring codes differ in exactly one bit.
    function automatic logic [ADDR_WIDTH:0] f_bin2gray(input logic [ADDR_WIDTH:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Gray to binary: XOR prefix running from the MSB down.
    function automatic logic [ADDR_WIDTH:0] f_gray2bin(input logic [ADDR_WIDTH:0] gray);
        logic [ADDR_WIDTH:0] bin;
        bin             = '0;
        bin[ADDR_WIDTH] = gray[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

    // State registers
    logic [ADDR_WIDTH:0] r_wbin;
    logic [ADDR_WIDTH:0] r_wptr;
    logic                r_wfull;
    logic                r_walmost_full;
    logic [ADDR_WIDTH:0] r_wlevel;
    logic                r_woverflow;

    // Next-state wires
    logic                w_wen;
    logic [ADDR_WIDTH:0] w_wbinnext;
    logic [ADDR_WIDTH:0] w_wgraynext;
    logic [ADDR_WIDTH:0] w_rbin;
    logic [ADDR_WIDTH:0] w_full_cmp;
    logic                w_wfull_next;
    logic [ADDR_WIDTH:0] w_wlevel_next;
    logic                w_walmost_full_next;
    logic                w_woverflow_next;

    // Next-state logic: accepted write, pointers, full/level/flags, overflow.
    always_comb begin
        w_wen               = 1'b0;
        w_wbinnext          = r_wbin;
        w_wgraynext         = r_wptr;
        w_rbin              = '0;
        w_full_cmp          = '0;
        w_wfull_next        = 1'b0;
        w_wlevel_next       = '0;
        w_walmost_full_next = 1'b0;
        w_woverflow_next    = r_woverflow;

        // A write is only accepted when the registered full flag is clear.
        w_wen       = winc & ~r_wfull;
        w_wbinnext  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wen};
        w_wgraynext = f_bin2gray(w_wbinnext);

        // Full when the next write pointer is a full lap ahead of the read
        // pointer: in Gray code that means the top two bits inverted.
        w_full_cmp   = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
        w_wfull_next = (w_wgraynext == w_full_cmp);

        // Level uses modular subtraction so the pointer wrap is transparent.
        w_rbin              = f_gray2bin(wq2_rptr);
        w_wlevel_next       = w_wbinnext - w_rbin;
        w_walmost_full_next = (w_wlevel_next >= LP_AFULL_THRESH);

        // Sticky overflow; a new overflow beats a clear in the same cycle.
        if (winc & r_wfull) begin
            w_woverflow_next = 1'b1;
        end else if (wovf_clr) begin
            w_woverflow_next = 1'b0;
        end else begin
            w_woverflow_next = r_woverflow;
        end
    end

    // Register pointers and status; asynchronous reset clears everything.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= w_wfull_next;
            r_walmost_full <= w_walmost_full_next;
            r_wlevel       <= w_wlevel_next;
            r_woverflow    <= w_woverflow_next;
        end
    end

    // RAM write port is combinational; all status outputs come from registers.
    assign wen          = w_wen;
    assign waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full. The reference model counts writes and reads
// as plain integers; level = writes - reads, full = (level == depth).
module tb_fifo_wptr_full;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 12;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic          wovf_clr;
    logic [AW:0]   wq2_rptr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_wr   = 0;
    int m_rd   = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .wovf_clr    (wovf_clr),
        .wq2_rptr    (wq2_rptr),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Gray code of a counter value modulo 2^(AW+1)
    function automatic logic [AW:0] gray_of(input int v);
        logic [AW:0] b;
        b = (AW + 1)'(v);
        return b ^ (b >> 1);
    endfunction

    // Apply inputs, take one edge, advance the model, sample #1 later.
    task automatic drive_cycle(input logic inc, input logic clr, input int rd);
        bit acc;
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = gray_of(rd);
        @(posedge wclk);
        acc = inc && !m_full;
        if (inc && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (acc) m_wr++;
        m_rd   = rd;
        m_full = ((m_wr - m_rd) == DEPTH);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = '0;
        #2;
        n_tests++; if (wptr !== 5'd0)         begin n_fail++; $display("FAIL reset_wptr: got %b expected 00000", wptr); end
        n_tests++; if (wfull !== 1'b0)        begin n_fail++; $display("FAIL reset_wfull: got %b expected 0", wfull); end
        n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", walmost_full); end
        n_tests++; if (wlevel !== 5'd0)       begin n_fail++; $display("FAIL reset_wlevel: got %0d expected 0", wlevel); end
        n_tests++; if (woverflow !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", woverflow); end
        repeat (3) @(posedge wclk);
        #1;
        n_tests++; if (wptr !== 5'd0)  begin n_fail++; $display("FAIL reset_hold_wptr: got %b expected 00000", wptr); end
        n_tests++; if (waddr !== 4'd0) begin n_fail++; $display("FAIL reset_hold_waddr: got %0d expected 0", waddr); end
        winc = 1'b0; wrst_n = 1'b1;
        #1;
        n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", wen); end
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b1, 1'b0, 0);
            n_tests++; if (wlevel !== 5'(i))               begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, wlevel, i); end
            n_tests++; if (walmost_full !== 1'(i >= THR))  begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full, i >= THR); end
            n_tests++; if (wfull !== 1'(i == DEPTH))       begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, wfull, i == DEPTH); end
            n_tests++; if (wptr !== gray_of(i))            begin n_fail++; $display("FAIL fill_wptr[%0d]: got %b expected %b", i, wptr, gray_of(i)); end
        end
        n_tests++; if (wptr !== 5'b11000) begin n_fail++; $display("FAIL fill_wptr_full: got %b expected 11000", wptr); end
        n_tests++; if (waddr !== 4'd0)    begin n_fail++; $display("FAIL fill_waddr_full: got %0d expected 0", waddr); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1; wovf_clr = 1'b0;
            #1;
            n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d]: got %b expected 0", i, wen); end
            drive_cycle(1'b1, 1'b0, 0);
            n_tests++; if (wptr !== 5'b11000) begin n_fail++; $display("FAIL ovf_wptr[%0d]: got %b expected 11000", i, wptr); end
            n_tests++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set[%0d]: got %b expected 1", i, woverflow); end
            n_tests++; if (wlevel !== 5'd16)   begin n_fail++; $display("FAIL ovf_level[%0d]: got %0d expected 16", i, wlevel); end
        end
        drive_cycle(1'b1, 1'b1, 0);
        n_tests++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", woverflow); end
        drive_cycle(1'b0, 1'b1, 0);
        n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", woverflow); end
        drive_cycle(1'b0, 1'b0, 0);
        n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_stay_clear: got %b expected 0", woverflow); end
    endtask

    task automatic test_drain();
        winc = 1'b0; wq2_rptr = 5'b00001;
        #1;
        n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL drain_latency: got %b expected 1", wfull); end
        drive_cycle(1'b0, 1'b0, 1);
        n_tests++; if (wfull !== 1'b0)  begin n_fail++; $display("FAIL drain_full: got %b expected 0", wfull); end
        n_tests++; if (wlevel !== 5'd15) begin n_fail++; $display("FAIL drain_level15: got %0d expected 15", wlevel); end
        drive_cycle(1'b0, 1'b0, 2);
        n_tests++; if (wq2_rptr !== 5'b00011) begin n_fail++; $display("FAIL drain_rptr_code: got %b expected 00011", wq2_rptr); end
        n_tests++; if (wlevel !== 5'd14)      begin n_fail++; $display("FAIL drain_level14: got %0d expected 14", wlevel); end
    endtask

    task automatic test_wrap();
        logic [AW:0] prev;
        int rd_new;
        int lvl;
        bit saw_wrap;
        saw_wrap = 1'b0;
        prev = gray_of(m_wr);
        for (int k = 0; k < 40; k++) begin
            rd_new = m_rd + int'($urandom_range(0, 2));
            if (rd_new < m_wr + 1 - (DEPTH - 1)) rd_new = m_wr + 1 - (DEPTH - 1);
            if (rd_new > m_wr) rd_new = m_wr;
            drive_cycle(1'b1, 1'b0, rd_new);
            lvl = m_wr - m_rd;
            if ((m_wr % 32) == 0) saw_wrap = 1'b1;
            n_tests++; if ($countones(wptr ^ prev) != 1) begin n_fail++; $display("FAIL wrap_onebit[%0d]: got %b expected one-bit step from %b", k, wptr, prev); end
            n_tests++; if (wptr !== gray_of(m_wr))        begin n_fail++; $display("FAIL wrap_wptr[%0d]: got %b expected %b", k, wptr, gray_of(m_wr)); end
            n_tests++; if (wlevel !== 5'(lvl))            begin n_fail++; $display("FAIL wrap_level[%0d]: got %0d expected %0d", k, wlevel, lvl); end
            n_tests++; if (wfull !== 1'b0)                begin n_fail++; $display("FAIL wrap_full[%0d]: got %b expected 0", k, wfull); end
            n_tests++; if (walmost_full !== 1'(lvl >= THR)) begin n_fail++; $display("FAIL wrap_afull[%0d]: got %b expected %b", k, walmost_full, lvl >= THR); end
            n_tests++; if (waddr !== 4'(m_wr % DEPTH))    begin n_fail++; $display("FAIL wrap_waddr[%0d]: got %0d expected %0d", k, waddr, m_wr % DEPTH); end
            prev = gray_of(m_wr);
        end
        n_tests++; if (!saw_wrap) begin n_fail++; $display("FAIL wrap_coverage: got no wrap expected wrap through 0"); end
    endtask

    task automatic test_simultaneous();
        int guard;
        logic [AW:0] exp_ptr;
        guard = 0;
        while (!m_full && guard < 40) begin
            drive_cycle(1'b1, 1'b0, m_rd);
            guard++;
        end
        n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL sim_prefull: got %b expected 1", wfull); end
        exp_ptr = gray_of(m_wr);
        drive_cycle(1'b1, 1'b0, m_rd + 1);
        n_tests++; if (wptr !== exp_ptr)  begin n_fail++; $display("FAIL sim_reject_wptr: got %b expected %b", wptr, exp_ptr); end
        n_tests++; if (wfull !== 1'b0)    begin n_fail++; $display("FAIL sim_reject_full: got %b expected 0", wfull); end
        n_tests++; if (wlevel !== 5'd15)  begin n_fail++; $display("FAIL sim_reject_level: got %0d expected 15", wlevel); end
        n_tests++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL sim_reject_ovf: got %b expected 1", woverflow); end
        drive_cycle(1'b1, 1'b0, m_rd + 1);
        n_tests++; if (wptr !== gray_of(m_wr)) begin n_fail++; $display("FAIL sim_accept_wptr: got %b expected %b", wptr, gray_of(m_wr)); end
        n_tests++; if (wlevel !== 5'd15) begin n_fail++; $display("FAIL sim_accept_level: got %0d expected 15", wlevel); end
        n_tests++; if (wfull !== 1'b0)   begin n_fail++; $display("FAIL sim_accept_full: got %b expected 0", wfull); end
        drive_cycle(1'b0, 1'b1, m_rd);
        n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL sim_ovf_clear: got %b expected 0", woverflow); end
    endtask

    task automatic test_random();
        logic inc;
        logic clr;
        int rd_new;
        int lvl;
        for (int k = 0; k < 200; k++) begin
            inc    = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 7) == 0);
            rd_new = m_rd + int'($urandom_range(0, 1));
            if (rd_new > m_wr) rd_new = m_wr;
            winc = inc; wovf_clr = clr; wq2_rptr = gray_of(rd_new);
            #1;
            n_tests++; if (wen !== 1'(inc && !m_full)) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b expected %b", k, wen, inc && !m_full); end
            drive_cycle(inc, clr, rd_new);
            lvl = m_wr - m_rd;
            n_tests++; if (wlevel !== 5'(lvl))             begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", k, wlevel, lvl); end
            n_tests++; if (wfull !== 1'(m_full))           begin n_fail++; $display("FAIL rnd_full[%0d]: got %b expected %b", k, wfull, m_full); end
            n_tests++; if (walmost_full !== 1'(lvl >= THR)) begin n_fail++; $display("FAIL rnd_afull[%0d]: got %b expected %b", k, walmost_full, lvl >= THR); end
            n_tests++; if (wptr !== gray_of(m_wr))         begin n_fail++; $display("FAIL rnd_wptr[%0d]: got %b expected %b", k, wptr, gray_of(m_wr)); end
            n_tests++; if (woverflow !== 1'(m_ovf))        begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", k, woverflow, m_ovf); end
        end
    endtask

    task automatic test_midreset();
        winc = 1'b1; wovf_clr = 1'b0;
        #2;
        wrst_n = 1'b0;
        #1;
        n_tests++; if (wptr !== 5'd0)   begin n_fail++; $display("FAIL mrst_wptr: got %b expected 00000", wptr); end
        n_tests++; if (wlevel !== 5'd0) begin n_fail++; $display("FAIL mrst_level: got %0d expected 0", wlevel); end
        n_tests++; if (wfull !== 1'b0 || walmost_full !== 1'b0 || woverflow !== 1'b0)
            begin n_fail++; $display("FAIL mrst_flags: got full=%b afull=%b ovf=%b expected 0 0 0", wfull, walmost_full, woverflow); end
        @(posedge wclk);
        #1;
        n_tests++; if (wptr !== 5'd0) begin n_fail++; $display("FAIL mrst_pending: got %b expected 00000", wptr); end
        winc = 1'b0; wq2_rptr = '0; wrst_n = 1'b1;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        drive_cycle(1'b1, 1'b0, 0);
        n_tests++; if (wptr !== 5'b00001) begin n_fail++; $display("FAIL mrst_first_wptr: got %b expected 00001", wptr); end
        n_tests++; if (wlevel !== 5'd1)   begin n_fail++; $display("FAIL mrst_first_level: got %0d expected 1", wlevel); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and status controller for the asynchronous FIFO, running on wclk. It accepts write requests, generates the dual-port RAM write address and enable, and maintains the Gray-coded write pointer that is sent across to the read domain. It consumes the read pointer already double-synchronized into wclk (wq2_rptr) to produce full, almost-full, fill level and a sticky overflow error.

## Interface
- ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2^ADDR_WIDTH; must be ≥ 2
- AFULL_THRESH, 12, walmost_full asserts when the fill level is ≥ this value; range 1..2^ADDR_WIDTH
- wclk  in  1  write clock
- wrst_n  in  1  reset, asynchronous, active-low
- winc  in  1  write request for the current cycle
- wovf_clr  in  1  clears woverflow
- wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray code, already synchronized to wclk
- wen  out  1  RAM write enable = winc & ~wfull (combinational)
- waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
- wptr  out  ADDR_WIDTH+1  write pointer, Gray code, registered; goes to the read-side synchronizer
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  level ≥ AFULL_THRESH, registered
- wlevel  out  ADDR_WIDTH+1  fill level as seen from the write side, registered, 0..2^ADDR_WIDTH
- woverflow  out  1  sticky: a write was attempted while full

## Operation
- Internal binary pointer wbin, ADDR_WIDTH+1 bits.
- wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDR_WIDTH+1).
- wgraynext = (wbinnext >> 1) ^ wbinnext. wptr registers wgraynext.
- rbin = Gray-to-binary of wq2_rptr, computed combinationally with an XOR prefix from the MSB down.
- Full test uses Gray compare: wfull_next = (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
- wlevel_next = wbinnext − rbin, modulo 2^(ADDR_WIDTH+1).
- walmost_full_next = (wlevel_next ≥ AFULL_THRESH).
- Write while full (winc & wfull):
  - Dropped: no pointer change, wen = 0.
  - woverflow sets on the next edge.
- woverflow holds until wovf_clr is sampled high. If set and clear occur in the same cycle, set wins.
- Status is conservative:
  - The synchronized rptr lags the read domain, so wlevel may overestimate the true level and never underestimates it.
  - wfull may stay asserted after a read. It is never deasserted while the FIFO is actually full.
- wptr changes by exactly one bit per accepted write, including the wrap from 2^(A+1)−1 to 0.

## Timing
- Reset (async assert, synchronous-to-wclk release handled upstream):
  - wbin = 0, wptr = 0, wfull = 0, walmost_full = 0, wlevel = 0, woverflow = 0.
  - wen = 0 and waddr = 0 follow from these values.
- Write acceptance:
  - A write is accepted on the wclk rising edge where winc = 1 and wfull = 0.
  - RAM data is written at waddr on that same edge.
  - wptr, wlevel, wfull and walmost_full reflect the accepted write after that edge, with zero extra latency.
- Filling: the write that fills the last slot asserts wfull on the edge that accepts it. A winc in the very next cycle is rejected.
- Draining: a change on wq2_rptr updates wfull, wlevel and walmost_full on the following wclk edge (1-cycle latency).
- Simultaneous winc and wq2_rptr change in the same cycle: both are folded into the same next-state computation. Level and flags are consistent with both.
- Reset asserted mid-operation: all registers return to their reset values immediately, with no clock required. Any pending write is lost.

## Test plan
- Reset:
  - Stimulus: wrst_n low with winc = 1.
  - Required: all outputs 0; wen = 0 after release while winc is low; no pointer movement while reset is held.
- Fill, with ADDR_WIDTH = 4, AFULL_THRESH = 12, wq2_rptr held at 0:
  - 12 consecutive writes → walmost_full rises after the 12th edge with wlevel = 12.
  - 16th write → wfull = 1, wlevel = 16, wptr = 5'b11000, waddr = 0.
- Overflow:
  - From full, winc = 1 for 3 cycles → wen = 0, wptr unchanged, woverflow = 1 and held.
  - Then wovf_clr and winc both high in one cycle → woverflow stays 1.
  - Then wovf_clr alone → woverflow = 0.
- Drain release:
  - From full, set wq2_rptr = 5'b00001 → the next edge gives wfull = 0 and wlevel = 15.
  - Set wq2_rptr = 5'b00011 → wlevel = 14.
- Wrap:
  - Stream 40 writes while a model advances wq2_rptr, keeping the level between 1 and 15.
  - Required: wptr changes by a single bit at every step, including 5'b10000 → 5'b00000; wlevel always equals the model's count; wfull never asserts.
- Simultaneous events:
  - At wlevel = 16 (full), set winc = 1 and wq2_rptr to gray(1) in the same cycle → the write is rejected (wfull was 1), and the next edge gives wfull = 0, wlevel = 15.
  - Repeat at wlevel = 15 with one read → wlevel stays 15 and wfull = 0.
